// File: rtl/dsp_mem_pkg.sv
// Shared encodings for the DSP data-memory initiator: access widths, FSM states
// and the bit-reverse helper used for FFT reordering.
package dsp_mem_pkg;

  localparam logic [2:0] MEM_W_BYTE = 3'b000;
  localparam logic [2:0] MEM_W_HALF = 3'b001;
  localparam logic [2:0] MEM_W_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_FIN
  } state_t;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [15:0] bit_rev(input logic [15:0] v, input logic [4:0] n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(n)) r[4'(i)] = v[4'(int'(n) - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_block_mover_if.sv
// Request/response bus between the block mover (master) and data memory (slave).
interface dsp_block_mover_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_width;
  logic        mem_signed;
  logic        mem_circular;
  logic        mem_bit_reverse;
  logic [31:0] mem_base_addr;
  logic [31:0] mem_buffer_size;
  logic [4:0]  mem_fft_size_log2;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_write_data, mem_read, mem_write, mem_width, mem_signed,
           mem_circular, mem_bit_reverse, mem_base_addr, mem_buffer_size, mem_fft_size_log2,
    input  mem_read_data, mem_ready
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_read, mem_write, mem_width, mem_signed,
           mem_circular, mem_bit_reverse, mem_base_addr, mem_buffer_size, mem_fft_size_log2,
    output mem_read_data, mem_ready
  );

endinterface

// File: rtl/dsp_addr_gen.sv
// Address generation for the block mover: source address (linear or bit-reversed)
// and destination address, with the circular destination offset kept here.
module dsp_addr_gen
  import dsp_mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      load_off,
  input  logic             advance,
  input  logic [CNT_W-1:0] src_idx,
  input  logic [CNT_W-1:0] dst_idx,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic             src_bitrev,
  input  logic [4:0]       fft_log2,
  input  logic             dst_circ,
  input  logic [31:0]      dst_len,
  output logic [31:0]      src_addr,
  output logic [31:0]      dst_addr
);

  logic [31:0] dst_off;
  logic [31:0] dst_off_inc;
  logic [31:0] src_word;

  assign dst_off_inc = dst_off + 32'd4;

  always_comb begin
    src_word = src_bitrev ? {16'h0000, bit_rev(16'(src_idx), fft_log2)} : 32'(src_idx);
    src_addr = src_base + (src_word << 2);
    dst_addr = dst_circ ? (dst_base + dst_off) : (dst_base + (32'(dst_idx) << 2));
  end

  // The offset is accepted as < len and steps by one word, so an equality test replaces a modulo.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_off <= '0;
    end else if (load) begin
      dst_off <= load_off;
    end else if (advance && dst_circ) begin
      dst_off <= (dst_off_inc == dst_len) ? 32'd0 : dst_off_inc;
    end
  end

endmodule

// File: rtl/dsp_block_mover.sv
// DSP data-memory block mover: copies N words from a source to a destination region,
// with optional bit-reversed source order and circular destination addressing.
module dsp_block_mover
  import dsp_mem_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src_base,
  input  logic [31:0]      cmd_dst_base,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_src_bitrev,
  input  logic [4:0]       cmd_fft_log2,
  input  logic             cmd_dst_circ,
  input  logic [31:0]      cmd_dst_len,
  input  logic [31:0]      cmd_dst_off,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done,
  dsp_block_mover_if.master bus
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t           state;
  logic [31:0]      src_base;
  logic [31:0]      dst_base;
  logic [CNT_W-1:0] count;
  logic             src_bitrev;
  logic [4:0]       fft_log2;
  logic             dst_circ;
  logic [31:0]      dst_len;
  logic [CNT_W-1:0] idx;
  logic             abort_pend;
  logic [WAIT_W-1:0] wait_cnt;

  logic             accept;
  logic             cmd_bad;
  logic             last_word;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign last_word = ((idx + CNT_W'(1)) == count);

  assign bus.mem_width         = MEM_W_WORD;
  assign bus.mem_signed        = 1'b0;
  assign bus.mem_circular      = 1'b0;
  assign bus.mem_bit_reverse   = 1'b0;
  assign bus.mem_base_addr     = 32'd0;
  assign bus.mem_buffer_size   = 32'd0;
  assign bus.mem_fft_size_log2 = 5'd0;

  always_comb begin
    cmd_bad = (cmd_src_base[1:0] != 2'b00) || (cmd_dst_base[1:0] != 2'b00);
    if (cmd_src_bitrev && ((cmd_fft_log2 == 5'd0) || (cmd_fft_log2 > 5'd16) ||
                           (32'(cmd_count) > (32'd1 << cmd_fft_log2))))
      cmd_bad = 1'b1;
    if (cmd_dst_circ && ((cmd_dst_len == 32'd0) || (cmd_dst_len[1:0] != 2'b00) ||
                         (cmd_dst_off >= cmd_dst_len)))
      cmd_bad = 1'b1;
  end

  dsp_addr_gen #(.CNT_W(CNT_W)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_off   (cmd_dst_off),
    .advance    (state == ST_WR_REQ),
    .src_idx    (idx + CNT_W'(1)),
    .dst_idx    (idx),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .src_bitrev (src_bitrev),
    .fft_log2   (fft_log2),
    .dst_circ   (dst_circ),
    .dst_len    (dst_len),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr)
  );

  // Requests are registered, so the abort decision for a read is taken on the edge
  // entering RD_REQ; an RD_REQ entered without a request falls straight through to FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      cmd_ready          <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      words_done         <= '0;
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      src_base           <= '0;
      dst_base           <= '0;
      count              <= '0;
      src_bitrev         <= 1'b0;
      fft_log2           <= '0;
      dst_circ           <= 1'b0;
      dst_len            <= '0;
      idx                <= '0;
      abort_pend         <= 1'b0;
      wait_cnt           <= '0;
    end else begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      done          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            src_base   <= cmd_src_base;
            dst_base   <= cmd_dst_base;
            count      <= cmd_count;
            src_bitrev <= cmd_src_bitrev;
            fft_log2   <= cmd_fft_log2;
            dst_circ   <= cmd_dst_circ;
            dst_len    <= cmd_dst_len;
            words_done <= '0;
            error      <= 1'b0;
            idx        <= '0;
            abort_pend <= 1'b0;
            wait_cnt   <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            if (cmd_bad) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ST_FIN;
            end else if (cmd_count == '0) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              state <= ST_RD_REQ;
              if (!abort) begin
                bus.mem_read <= 1'b1;
                bus.mem_addr <= cmd_src_base;
              end
            end
          end
        end
        ST_RD_REQ: begin
          if (!bus.mem_read) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            if (abort) abort_pend <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (bus.mem_ready) begin
            bus.mem_write_data <= bus.mem_read_data;
            bus.mem_write      <= 1'b1;
            bus.mem_addr       <= dst_addr;
            state              <= ST_WR_REQ;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_WR_REQ: begin
          words_done <= words_done + CNT_W'(1);
          idx        <= idx + CNT_W'(1);
          if (last_word) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            state <= ST_RD_REQ;
            if (!(abort || abort_pend)) begin
              bus.mem_read <= 1'b1;
              bus.mem_addr <= src_addr;
            end
          end
        end
        ST_FIN: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
